alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DEPTH, 2, number of result buffer entries; legal values 2 or 4.
REQ-002 Parameter: CNT_W, 8, width of the overflow event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  adder/subtractor outputs and operand MSBs are valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  5  Result from the adder/subtractor.
REQ-008 in_cout  input  1  Cout from the adder/subtractor.
REQ-009 in_sub  input  1  cin applied to the adder/subtractor: 1 = A-B, 0 = A+B.
REQ-010 in_a_msb  input  1  bit 4 of operand A.
REQ-011 in_b_msb  input  1  bit 4 of operand B, before inversion.
REQ-012 out_valid  output  1  head entry is present.
REQ-013 out_ready  input  1  consumer takes the head entry this cycle.
REQ-014 out_result  output  5  head entry result.
REQ-015 out_flags  output  4  head entry flags {N,Z,C,V}, with N at bit 3.
REQ-016 ovf_count  output  CNT_W  saturating count of accepted entries with V=1.

Function
REQ-017 Accept occurs when in_valid && in_ready, and shall write one entry at the tail.
REQ-018 Pop occurs when out_valid && out_ready, and shall remove the head entry.
REQ-019 in_ready shall be 1 if and only if occupancy < DEPTH; there is no same-cycle pass-through when the buffer is full.
REQ-020 Latency: an entry accepted in cycle t shall be visible at the head (out_valid=1) in cycle t+1 when the buffer was empty.
REQ-021 Simultaneous accept and pop with 0 < occupancy < DEPTH shall leave occupancy unchanged and preserve FIFO order.
REQ-022 Head and tail pointers shall wrap modulo DEPTH.
REQ-023 Flag N shall equal in_result[4].
REQ-024 Flag Z shall be 1 when in_result == 5'b00000.
REQ-025 Flag C shall equal in_cout as supplied; for subtraction, C=1 means no borrow.
REQ-026 Flag V for addition (in_sub=0) shall be (a_msb == b_msb) && (r4 != a_msb).
REQ-027 Flag V for subtraction (in_sub=1) shall be (a_msb != b_msb) && (r4 != a_msb).
REQ-028 Flags shall be computed at accept time and stored with the entry.
REQ-029 ovf_count shall increment on each accept with V=1, and shall hold at 2^CNT_W-1 once reached.
REQ-030 When out_valid=0, out_result and out_flags shall drive 0.
REQ-031 Inputs other than in_valid shall be ignored when no accept occurs.

Reset
REQ-032 While rst=1 at a rising edge, the stage shall empty the buffer (occupancy 0), set out_valid=0, out_result=0, out_flags=0 and ovf_count=0.
REQ-033 During a cycle with rst=1, an accept or pop shall have no effect; after reset the in-flight entry is lost.
REQ-034 in_ready shall be 1 in the first cycle after rst deasserts.

Structure
REQ-035 Shared package alu_pkg shall hold DATA_W=5 and the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
REQ-036 Sub-module alu_flag_gen (combinational, in_result/in_cout/in_sub/MSBs to 4-bit flags) shall be instantiated once.
REQ-037 Buffer storage shall be a register array of DEPTH x (5+4) bits with head/tail pointers and an occupancy counter.

Verification
REQ-038 Add overflow: in_sub=0, A=7, B=9, result=5'b10000, cout=0 -> out_result=16, flags N=1 Z=0 C=0 V=1, ovf_count=1.
REQ-039 Subtract equal: in_sub=1, A=3, B=3, result=0, cout=1 -> flags N=0 Z=1 C=1 V=0, ovf_count unchanged.
REQ-040 Back-pressure: out_ready=0 with 2 accepts (DEPTH=2) -> in_ready=0; a held third input is accepted in the cycle after one pop; output order is 1,2,3.
REQ-041 Streaming: in_valid=1 and out_ready=1 continuously for 10 entries -> one entry per cycle, in order, occupancy never exceeds 1.
REQ-042 Saturation: 300 accepts with V=1 and CNT_W=8 -> ovf_count=255.
REQ-043 Reset mid-stream: rst=1 with 2 entries buffered -> next cycle out_valid=0, in_ready=1, ovf_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and the stored entry layout for the
// ALU result stage.
package alu_pkg;

    localparam int DATA_W = 5;
    localparam int FLAG_W = 4;

    // Flag vector layout {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // One buffered result together with the flags captured at accept time
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V generation from the adder/subtractor outputs and
// the original operand sign bits (B before inversion).
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] result,
    input  logic              cout,
    input  logic              sub,
    input  logic              a_msb,
    input  logic              b_msb,
    output logic [FLAG_W-1:0] flags
);

    logic r_msb;
    logic ovf;

    assign r_msb = result[DATA_W-1];

    // Signed overflow: for A+B the operands share a sign the result lost;
    // for A-B the operands differ in sign and the result left A's sign.
    always_comb begin
        ovf = 1'b0;
        if (sub) begin
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end
    end

    // Assemble the flag vector; C is the raw carry, so for subtraction
    // C=1 means no borrow.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = r_msb;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = cout;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage: computes flags for each accepted ALU result and holds the
// result+flags in a small FIFO, counting signed overflows (saturating).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready depends only on occupancy (no pass-through when full);
// out_valid/out_result/out_flags depend only on stored state, and the
// data outputs read 0 while out_valid is 0.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_cout,
    input  logic              in_sub,
    input  logic              in_a_msb,
    input  logic              in_b_msb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   occ;
    logic [FLAG_W-1:0] new_flags;
    entry_t           new_entry;
    logic             acc;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    alu_flag_gen u_flag_gen (
        .result (in_result),
        .cout   (in_cout),
        .sub    (in_sub),
        .a_msb  (in_a_msb),
        .b_msb  (in_b_msb),
        .flags  (new_flags)
    );

    assign new_entry.result = in_result;
    assign new_entry.flags  = new_flags;

    // Handshake qualification; a reset cycle never transfers anything.
    always_comb begin
        in_ready  = (occ < (PTR_W + 1)'(DEPTH));
        out_valid = (occ != '0);
        acc       = in_valid && in_ready && !rst;
        pop       = out_valid && out_ready && !rst;
    end

    // Head entry drives the outputs, forced to zero when empty.
    always_comb begin
        out_result = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_result = mem[head].result;
            out_flags  = mem[head].flags;
        end
    end

    // Storage write at the tail on accept; contents need no reset since
    // occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[tail] <= new_entry;
        end
    end

    // Pointers, occupancy and the saturating overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            ovf_count <= '0;
        end else begin
            if (acc) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({acc, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (acc && new_flags[FLAG_V] && (ovf_count != '1)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule
